// File: rtl/stopwatch_sequencer.sv
// ============================================================================
// stopwatch_sequencer
//
// Control and timekeeping core of the stopwatch. It sits between the debounced
// key-edge pulses and the 7-segment driver. It owns the run/pause/lap/clear
// state machine and the cascaded BCD time registers (min, ten_sec, sec,
// subsec). It gates the 1/10 s prescaler through timer_enable/timer_reset, and
// it selects either the live time or a frozen lap time for the display.
//
// Parameters:
//   SATURATE     0 = wrap 9:59.9 -> 0:00.0
//                1 = hold at 9:59.9 and drop into PAUSED
//   BLINK_TICKS  ticks per half-period of the lap decimal-point blink (1..15).
//                This parameter exists only when STOPWATCH_LAP_BLINK_EN is
//                defined.
//
// Optional feature macro: STOPWATCH_LAP_BLINK_EN
//   When this macro is defined, the decimal points blink while LAP is shown.
//   When it is undefined, no blink logic is built and disp_dp is constant.
//
// Ports:
//   clock         in   1   system clock
//   reset_n       in   1   asynchronous active-low reset
//   start_stop    in   1   one-cycle key pulse, start/stop
//   reset_lap     in   1   one-cycle key pulse, lap/clear
//   tick          in   1   one-cycle 1/10 s pulse from the prescaler
//   timer_enable  out  1   prescaler enable (RUNNING or LAP)
//   timer_reset   out  1   one-cycle prescaler clear, follows every clear
//   live_digits   out  16  {min, ten_sec, sec, subsec}, BCD
//   disp_digits   out  16  value shown on the display, same packing
//   disp_dp       out  4   decimal-point mask, bit3 = min ... bit0 = subsec
//   state_out     out  2   IDLE=0, RUNNING=1, PAUSED=2, LAP=3
// ============================================================================
module stopwatch_sequencer #(
    parameter int SATURATE = 0
`ifdef STOPWATCH_LAP_BLINK_EN
    ,
    parameter int BLINK_TICKS = 5
`endif
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start_stop,
    input  logic        reset_lap,
    input  logic        tick,
    output logic        timer_enable,
    output logic        timer_reset,
    output logic [15:0] live_digits,
    output logic [15:0] disp_digits,
    output logic [3:0]  disp_dp,
    output logic [1:0]  state_out
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2,
        LAP     = 2'd3
    } state_t;

    // Separators after the minute digit and after the seconds digit.
    localparam logic [3:0]  DP_NORMAL = 4'b1010;
    localparam logic [15:0] MAX_TIME  = 16'h9599;

    state_t      state;
    state_t      state_next;

    logic [3:0]  min;
    logic [3:0]  ten_sec;
    logic [3:0]  sec;
    logic [3:0]  subsec;
    logic [3:0]  min_next;
    logic [3:0]  ten_sec_next;
    logic [3:0]  sec_next;
    logic [3:0]  subsec_next;

    logic [15:0] lap_reg;

    logic        active;
    logic        counting;
    logic        at_max;
    logic        saturate_hit;
    logic        do_clear;
    logic        do_capture;

    assign live_digits  = {min, ten_sec, sec, subsec};
    assign state_out    = state;

    // The prescaler runs only while time is advancing; this includes LAP,
    // because the live time keeps counting behind the frozen lap display.
    assign active       = (state == RUNNING) || (state == LAP);
    assign timer_enable = active;
    assign counting     = tick && active;
    assign at_max       = (live_digits == MAX_TIME);
    assign saturate_hit = (SATURATE != 0) && counting && at_max;

    assign disp_digits  = (state == LAP) ? lap_reg : live_digits;

    // ------------------------------------------------------------------------
    // Next-state logic. start_stop is tested first in every state, so a
    // simultaneous reset_lap is dropped. A saturating rollover overrides
    // everything else and parks the machine in PAUSED. This still holds
    // when start_stop would otherwise have resumed or stopped it.
    // ------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        do_clear   = 1'b0;
        do_capture = 1'b0;

        case (state)
            IDLE: begin
                if (start_stop) begin
                    state_next = RUNNING;
                end else if (reset_lap) begin
                    do_clear = 1'b1;
                end
            end
            RUNNING: begin
                if (start_stop) begin
                    state_next = PAUSED;
                end else if (reset_lap) begin
                    state_next = LAP;
                    do_capture = 1'b1;
                end
            end
            LAP: begin
                if (start_stop) begin
                    state_next = PAUSED;
                end else if (reset_lap) begin
                    do_capture = 1'b1;
                end
            end
            PAUSED: begin
                if (start_stop) begin
                    state_next = RUNNING;
                end else if (reset_lap) begin
                    state_next = IDLE;
                    do_clear   = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (saturate_hit) begin
            state_next = PAUSED;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------------
    // BCD cascade. A clear always beats a coincident tick. A clear can only
    // happen in IDLE or PAUSED, where ticks are ignored anyway, so the
    // priority is for safety only. Each digit wraps at its own limit. The top
    // of the range is handled as a whole, so the minute digit never carries
    // past 9.
    // ------------------------------------------------------------------------
    always_comb begin
        min_next     = min;
        ten_sec_next = ten_sec;
        sec_next     = sec;
        subsec_next  = subsec;

        if (do_clear) begin
            min_next     = 4'd0;
            ten_sec_next = 4'd0;
            sec_next     = 4'd0;
            subsec_next  = 4'd0;
        end else if (counting) begin
            if (at_max) begin
                if (SATURATE == 0) begin
                    min_next     = 4'd0;
                    ten_sec_next = 4'd0;
                    sec_next     = 4'd0;
                    subsec_next  = 4'd0;
                end
            end else if (subsec != 4'd9) begin
                subsec_next = subsec + 4'd1;
            end else begin
                subsec_next = 4'd0;
                if (sec != 4'd9) begin
                    sec_next = sec + 4'd1;
                end else begin
                    sec_next = 4'd0;
                    if (ten_sec != 4'd5) begin
                        ten_sec_next = ten_sec + 4'd1;
                    end else begin
                        ten_sec_next = 4'd0;
                        min_next     = (min == 4'd9) ? 4'd0 : min + 4'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            min     <= 4'd0;
            ten_sec <= 4'd0;
            sec     <= 4'd0;
            subsec  <= 4'd0;
        end else begin
            min     <= min_next;
            ten_sec <= ten_sec_next;
            sec     <= sec_next;
            subsec  <= subsec_next;
        end
    end

    // ------------------------------------------------------------------------
    // The lap register captures the value the live counters hold *before*
    // this cycle's tick is applied. Because of this, a tick that coincides
    // with a lap key press does not appear in the captured lap time.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lap_reg <= 16'h0000;
        end else if (do_capture) begin
            lap_reg <= live_digits;
        end else if (do_clear) begin
            lap_reg <= 16'h0000;
        end
    end

    // The prescaler clear is registered. It lines up with the first cycle in
    // which the counters read zero.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            timer_reset <= 1'b0;
        end else begin
            timer_reset <= do_clear;
        end
    end

`ifdef STOPWATCH_LAP_BLINK_EN
    localparam logic [3:0] BLINK_LAST = 4'(BLINK_TICKS - 1);

    logic [3:0] blink_cnt;
    logic       blink;

    // ------------------------------------------------------------------------
    // The blink counter restarts only when LAP is first entered. Further lap
    // captures while already in LAP leave the blink phase alone, so the
    // flashing stays steady.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt <= 4'd0;
            blink     <= 1'b0;
        end else if ((state != LAP) && (state_next == LAP)) begin
            blink_cnt <= 4'd0;
            blink     <= 1'b0;
        end else if ((state == LAP) && tick) begin
            if (blink_cnt >= BLINK_LAST) begin
                blink_cnt <= 4'd0;
                blink     <= ~blink;
            end else begin
                blink_cnt <= blink_cnt + 4'd1;
            end
        end
    end

    assign disp_dp = ((state == LAP) && blink) ? 4'b0000 : DP_NORMAL;
`else
    assign disp_dp = DP_NORMAL;
`endif

endmodule

// File: tb/tb_stopwatch_sequencer.sv
// ============================================================================
// tb_stopwatch_sequencer
//
// Drives two instances of stopwatch_sequencer with identical key/tick
// stimulus: one wrapping (SATURATE = 0) and one saturating (SATURATE = 1).
// A reference model tracks elapsed time as a plain count of tenths of a
// second and converts it to BCD with division. It is compared against both
// instances every cycle. Hand-computed literal checks pin the model at the
// interesting points of the sequence.
// ============================================================================
module tb_stopwatch_sequencer;

    logic        clock;
    logic        reset_n;
    logic        start_stop;
    logic        reset_lap;
    logic        tick;

    logic        timer_enable [2];
    logic        timer_reset  [2];
    logic [15:0] live_digits  [2];
    logic [15:0] disp_digits  [2];
    logic [3:0]  disp_dp      [2];
    logic [1:0]  state_out    [2];

    int checks = 0;
    int errors = 0;

    // Model state per instance: time and lap are in tenths of a second.
    int m_time      [2];
    int m_lap       [2];
    int m_state     [2];
    bit m_trst      [2];
    int m_lap_ticks [2];

`ifdef STOPWATCH_LAP_BLINK_EN
    localparam int BLINK = 5;
`endif

    stopwatch_sequencer #(.SATURATE(0)) dut_wrap (
        .clock        (clock),
        .reset_n      (reset_n),
        .start_stop   (start_stop),
        .reset_lap    (reset_lap),
        .tick         (tick),
        .timer_enable (timer_enable[0]),
        .timer_reset  (timer_reset[0]),
        .live_digits  (live_digits[0]),
        .disp_digits  (disp_digits[0]),
        .disp_dp      (disp_dp[0]),
        .state_out    (state_out[0])
    );

    stopwatch_sequencer #(.SATURATE(1)) dut_sat (
        .clock        (clock),
        .reset_n      (reset_n),
        .start_stop   (start_stop),
        .reset_lap    (reset_lap),
        .tick         (tick),
        .timer_enable (timer_enable[1]),
        .timer_reset  (timer_reset[1]),
        .live_digits  (live_digits[1]),
        .disp_digits  (disp_digits[1]),
        .disp_dp      (disp_dp[1]),
        .state_out    (state_out[1])
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [15:0] to_bcd(input int t);
        int m;
        int s;
        m = t / 600;
        s = (t / 10) % 60;
        return {4'(m), 4'(s / 10), 4'(s % 10), 4'(t % 10)};
    endfunction

    function automatic logic [3:0] model_dp(input int k);
`ifdef STOPWATCH_LAP_BLINK_EN
        if (m_state[k] == 3 && ((m_lap_ticks[k] / BLINK) % 2) == 1) begin
            return 4'b0000;
        end
`endif
        return (k >= 0) ? 4'b1010 : 4'b1010;
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // One clock of stimulus. Inputs change 3 time units after a rising edge.
    task automatic applyStimulus(input bit ss, input bit rl, input bit tk);
        start_stop = ss;
        reset_lap  = rl;
        tick       = tk;
        @(posedge clock);
        #3;
        start_stop = 1'b0;
        reset_lap  = 1'b0;
        tick       = 1'b0;
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1);
        end
    endtask

    task automatic model_step(input int k, input bit sat);
        bit active;
        bit counting;
        bit at_max;
        bit clear;
        bit capture;
        int nxt;
        active   = (m_state[k] == 1) || (m_state[k] == 3);
        counting = tick && active;
        at_max   = (m_time[k] == 5999);
        clear    = reset_lap && !start_stop && !active;
        capture  = reset_lap && !start_stop && active;
        nxt      = m_state[k];
        if (start_stop) begin
            nxt = active ? 2 : 1;
        end else if (reset_lap) begin
            nxt = active ? 3 : 0;
        end
        if (sat && counting && at_max) begin
            nxt = 2;
        end
        if (m_state[k] != 3 && nxt == 3) begin
            m_lap_ticks[k] = 0;
        end else if (m_state[k] == 3 && tick) begin
            m_lap_ticks[k] = m_lap_ticks[k] + 1;
        end
        if (capture) begin
            m_lap[k] = m_time[k];
        end else if (clear) begin
            m_lap[k] = 0;
        end
        if (clear) begin
            m_time[k] = 0;
        end else if (counting) begin
            m_time[k] = at_max ? (sat ? 5999 : 0) : m_time[k] + 1;
        end
        m_trst[k]  = clear;
        m_state[k] = nxt;
    endtask

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 2; k++) begin
                m_time[k]      = 0;
                m_lap[k]       = 0;
                m_state[k]     = 0;
                m_trst[k]      = 1'b0;
                m_lap_ticks[k] = 0;
            end
        end else begin
            model_step(0, 1'b0);
            model_step(1, 1'b1);
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(posedge clock) begin
        #2;
        if (reset_n) begin
            for (int k = 0; k < 2; k++) begin
                checkOutput($sformatf("model%0d.state", k), 16'(state_out[k]), 16'(m_state[k]));
                checkOutput($sformatf("model%0d.live", k), live_digits[k], to_bcd(m_time[k]));
                checkOutput($sformatf("model%0d.disp", k), disp_digits[k],
                            (m_state[k] == 3) ? to_bcd(m_lap[k]) : to_bcd(m_time[k]));
                checkOutput($sformatf("model%0d.dp", k), 16'(disp_dp[k]), 16'(model_dp(k)));
                checkOutput($sformatf("model%0d.tenable", k), 16'(timer_enable[k]),
                            16'((m_state[k] == 1) || (m_state[k] == 3)));
                checkOutput($sformatf("model%0d.treset", k), 16'(timer_reset[k]), 16'(m_trst[k]));
            end
        end
    end

    task automatic check_reset_values(input string tag);
        for (int k = 0; k < 2; k++) begin
            checkOutput($sformatf("%s%0d.state", tag, k), 16'(state_out[k]), 16'd0);
            checkOutput($sformatf("%s%0d.live", tag, k), live_digits[k], 16'h0000);
            checkOutput($sformatf("%s%0d.disp", tag, k), disp_digits[k], 16'h0000);
            checkOutput($sformatf("%s%0d.dp", tag, k), 16'(disp_dp[k]), 16'b1010);
            checkOutput($sformatf("%s%0d.tenable", tag, k), 16'(timer_enable[k]), 16'd0);
            checkOutput($sformatf("%s%0d.treset", tag, k), 16'(timer_reset[k]), 16'd0);
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        start_stop = 1'b0;
        reset_lap  = 1'b0;
        tick       = 1'b0;
        repeat (2) @(posedge clock);
        #3;
        check_reset_values("reset");
        reset_n = 1'b1;

        // Start, then 123 ticks -> 0:12.3
        applyStimulus(1'b1, 1'b0, 1'b0);
        run_ticks(123);
        checkOutput("run123.live", live_digits[0], 16'h0123);
        checkOutput("run123.state", 16'(state_out[0]), 16'd1);
        checkOutput("run123.tenable", 16'(timer_enable[0]), 16'd1);

        // Pause, ticks ignored, then clear
        applyStimulus(1'b1, 1'b0, 1'b0);
        run_ticks(5);
        checkOutput("paused.live", live_digits[0], 16'h0123);
        checkOutput("paused.state", 16'(state_out[0]), 16'd2);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("clear.live", live_digits[0], 16'h0000);
        checkOutput("clear.state", 16'(state_out[0]), 16'd0);
        checkOutput("clear.treset", 16'(timer_reset[0]), 16'd1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("clear.treset_drop", 16'(timer_reset[0]), 16'd0);

        // Lap capture at 0:04.5, keep running to 0:06.5, recapture
        applyStimulus(1'b1, 1'b0, 1'b0);
        run_ticks(45);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("lap1.state", 16'(state_out[0]), 16'd3);
        checkOutput("lap1.disp", disp_digits[0], 16'h0045);
        run_ticks(20);
        checkOutput("lap1.disp_frozen", disp_digits[0], 16'h0045);
        checkOutput("lap1.live", live_digits[0], 16'h0065);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("lap2.disp", disp_digits[0], 16'h0065);

        // Back to RUNNING, then both keys at once: start_stop wins
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("both_keys.state", 16'(state_out[0]), 16'd2);
        checkOutput("both_keys.live", live_digits[0], 16'h0065);

        // Tick coincident with clear in PAUSED: clear wins
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("tick_clear.live", live_digits[0], 16'h0000);
        checkOutput("tick_clear.state", 16'(state_out[0]), 16'd0);

        // Tick coincident with stop out of RUNNING is counted
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("stop_tick.live", live_digits[0], 16'h0001);
        checkOutput("stop_tick.state", 16'(state_out[0]), 16'd2);

        // Run up to 9:59.9 and cross the top
        applyStimulus(1'b1, 1'b0, 1'b0);
        run_ticks(5998);
        checkOutput("top.live0", live_digits[0], 16'h9599);
        checkOutput("top.live1", live_digits[1], 16'h9599);
        run_ticks(1);
        checkOutput("wrap.live", live_digits[0], 16'h0000);
        checkOutput("wrap.state", 16'(state_out[0]), 16'd1);
        checkOutput("sat.live", live_digits[1], 16'h9599);
        checkOutput("sat.state", 16'(state_out[1]), 16'd2);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("sat_resume.state", 16'(state_out[1]), 16'd1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("sat_ss_tick.state", 16'(state_out[1]), 16'd2);
        checkOutput("sat_ss_tick.live", live_digits[1], 16'h9599);
        checkOutput("wrap_resume.state", 16'(state_out[0]), 16'd1);
        checkOutput("wrap_resume.live", live_digits[0], 16'h0000);

        // Reset in the middle of counting at 0:37.7
        run_ticks(377);
        checkOutput("midreset.pre_live", live_digits[0], 16'h0377);
        tick    = 1'b1;
        reset_n = 1'b0;
        #1;
        check_reset_values("async");
        @(posedge clock);
        #3;
        tick    = 1'b0;
        reset_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("after_reset.live", live_digits[0], 16'h0000);

        // Decimal points while in LAP
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("lapdp.enter", 16'(disp_dp[0]), 16'b1010);
        run_ticks(4);
        checkOutput("lapdp.t4", 16'(disp_dp[0]), 16'b1010);
        run_ticks(1);
`ifdef STOPWATCH_LAP_BLINK_EN
        checkOutput("lapdp.t5", 16'(disp_dp[0]), 16'b0000);
        run_ticks(4);
        checkOutput("lapdp.t9", 16'(disp_dp[0]), 16'b0000);
        run_ticks(1);
        checkOutput("lapdp.t10", 16'(disp_dp[0]), 16'b1010);
`else
        checkOutput("lapdp.t5", 16'(disp_dp[0]), 16'b1010);
`endif

        repeat (2) @(posedge clock);
        #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stopwatch_sequencer.md
Name: stopwatch_sequencer

Overview:
- Control and timekeeping core of the stopwatch, between the debounced key-edge pulses and the 7-segment driver.
- Owns the run/pause/lap/clear state machine and the cascaded BCD time registers (min, ten_sec, sec, subsec).
- Gates the 1/10 s prescaler timer_counter through `timer_enable` and `timer_reset`.
- Selects live time or a frozen lap time for display.

Parameters:
- SATURATE, 0: 0 = wrap 9:59.9 -> 0:00.0; 1 = hold at 9:59.9 and force PAUSED.
- BLINK_TICKS, 5: ticks per half-period of the lap DP blink (optional feature only); range 1..15.

Ports:
- clock  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- start_stop  input  1  one-cycle key-press pulse, start/stop
- reset_lap  input  1  one-cycle key-press pulse, lap/clear
- tick  input  1  one-cycle 1/10 s pulse from the prescaler overflow
- timer_enable  output  1  enable for the prescaler timer_counter
- timer_reset  output  1  one-cycle clear for the prescaler
- live_digits  output  16  {min, ten_sec, sec, subsec}, BCD, 4 bits each
- disp_digits  output  16  value shown on the display, same packing
- disp_dp  output  4  decimal-point mask, bit3 = min digit ... bit0 = subsec digit
- state_out  output  2  encoded state

Behaviour:
- Interface: one clock, `clock`; `reset_n` is asynchronous, active-low. All state registers reset asynchronously.
- Reset values: state = IDLE; all BCD counters 0; lap register 0; timer_reset = 0.
- Derived outputs at reset: timer_enable = 0; disp_digits = 0; disp_dp = 4'b1010.
- State encoding: IDLE = 0, RUNNING = 1, PAUSED = 2, LAP = 3.
- timer_enable = (state == RUNNING || state == LAP); combinational from the state register.
- Transitions, evaluated on registered state:
  - IDLE: start_stop -> RUNNING. reset_lap -> clear (counters and lap to 0, timer_reset pulse), stay IDLE.
  - RUNNING: start_stop -> PAUSED. reset_lap -> LAP; lap register <= live value.
  - LAP: start_stop -> PAUSED. reset_lap -> lap register <= live value, stay LAP.
  - PAUSED: start_stop -> RUNNING. reset_lap -> IDLE plus clear.
- Simultaneous start_stop and reset_lap: start_stop wins, reset_lap is dropped.
- Lap capture takes the pre-update register value, even if tick is coincident.
- Counting: on tick while the current state is RUNNING or LAP, the BCD cascade increments; result is visible the next cycle.
  - Carry limits: subsec 0-9, sec 0-9, ten_sec 0-5, min 0-9.
- Tick in the same cycle as start_stop out of RUNNING/LAP: the tick is counted.
- Tick in the same cycle as a clear: the clear wins.
- Tick outside RUNNING/LAP: ignored.
- Rollover at 9:59.9 with a tick:
  - SATURATE = 0: wrap to 0:00.0, state unchanged.
  - SATURATE = 1: value holds 9:59.9 and state -> PAUSED next cycle. If start_stop is coincident, it still yields PAUSED.
- timer_reset: registered, high for exactly one cycle after any clear; otherwise 0.
- disp_digits: lap register when state == LAP, else live_digits; combinational mux.
- disp_dp: constant 4'b1010 (separators after min and after sec).
- Counter values never leave the legal BCD ranges, including across reset mid-count.

Optional Feature:
- Macro: STOPWATCH_LAP_BLINK_EN.
- Defined:
  - A 4-bit blink counter advances on tick in LAP and toggles a blink flag every BLINK_TICKS ticks.
  - disp_dp = blink ? 4'b0000 : 4'b1010 while in LAP.
  - Counter and flag clear on entering LAP and on reset.
- Undefined: no blink logic synthesized; disp_dp always 4'b1010.

Test Plan:
- Reset, then start_stop, then 123 ticks -> live_digits = 16'h0123 (0:12.3), state_out = 1, timer_enable = 1.
- From 0:12.3: start_stop, 5 ticks, then reset_lap -> digits stay 16'h0123 while PAUSED; after clear, all 0, state 0, timer_reset high for one cycle.
- RUNNING at 16'h0045: reset_lap, then 20 ticks -> disp_digits = 16'h0045, live_digits = 16'h0065. Second reset_lap -> disp_digits = 16'h0065.
- Load to 16'h9599 and tick:
  - SATURATE = 0 -> 16'h0000, still RUNNING.
  - SATURATE = 1 -> 16'h9599, state 2.
- start_stop and reset_lap in the same cycle in RUNNING -> state PAUSED, lap register unchanged. Tick coincident with clear in PAUSED -> digits 0.
- reset_n asserted mid-count at 16'h0377 -> all outputs at reset values immediately, asynchronously. With STOPWATCH_LAP_BLINK_EN and BLINK_TICKS = 5, in LAP, disp_dp toggles every 5 ticks.
